// File: rtl/dds_sweep_ctrl.sv
// Frame-driven DDS controller: UART command parser, waveform selects and a KW frequency sweep.
// Optional `DDS_SWEEP_PINGPONG_EN selects a bidirectional sweep in place of the sawtooth wrap.
module dds_sweep_ctrl #(
    parameter int unsigned KW_W    = 12,
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned KW_RST  = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [7:0]      Rx_Data,
    input  logic            Rx_Done,
    output logic            SW_Sin_Out,
    output logic            SW_Square_Out,
    output logic            SW_Sawtooth_Out,
    output logic [KW_W-1:0] KW_Out,
    output logic            Sweep_Busy,
    output logic            Cmd_Ack,
    output logic            Cmd_Err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {P_HUNT, P_GOT_HDR, P_GOT_CMD, P_GOT_HI} parse_t;
    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_STEP} sweep_t;

    parse_t             parse_q;
    sweep_t             sweep_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [2:0]         cmd_q;
    logic [7:0]         d_hi_q;
    logic [KW_W-1:0]    start_q;
    logic [KW_W-1:0]    stop_q;
    logic [KW_W-1:0]    step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_cnt_q;

    logic [15:0]        data_c;
    logic [KW_W:0]      nxt_up_c;
    logic               up_fits_c;
    logic               run_ok_c;

    assign data_c    = {d_hi_q, Rx_Data};
    assign nxt_up_c  = {1'b0, KW_Out} + {1'b0, step_q};
    assign up_fits_c = (nxt_up_c <= {1'b0, stop_q});
    assign run_ok_c  = (start_q <= stop_q) && (step_q != '0);

`ifdef DDS_SWEEP_PINGPONG_EN
    logic            dir_up_q;
    logic            single_q;
    logic [KW_W:0]   nxt_dn_c;
    logic [KW_W-1:0] dn_clamp_c;

    // Downward step saturates at START (borrow or below START)
    assign nxt_dn_c   = {1'b0, KW_Out} - {1'b0, step_q};
    assign dn_clamp_c = (nxt_dn_c[KW_W] || (nxt_dn_c[KW_W-1:0] < start_q)) ? start_q
                                                                           : nxt_dn_c[KW_W-1:0];
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            parse_q         <= P_HUNT;
            sweep_q         <= S_IDLE;
            tmo_cnt_q       <= '0;
            cmd_q           <= '0;
            d_hi_q          <= '0;
            start_q         <= KW_W'(KW_RST);
            stop_q          <= '1;
            step_q          <= KW_W'(1);
            dwell_q         <= '0;
            dwell_cnt_q     <= '0;
            KW_Out          <= KW_W'(KW_RST);
            SW_Sin_Out      <= 1'b0;
            SW_Square_Out   <= 1'b0;
            SW_Sawtooth_Out <= 1'b0;
            Sweep_Busy      <= 1'b0;
            Cmd_Ack         <= 1'b0;
            Cmd_Err         <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
            dir_up_q        <= 1'b1;
            single_q        <= 1'b0;
`endif
        end else begin
            Cmd_Ack <= 1'b0;
            Cmd_Err <= 1'b0;

            // Sweep engine; a frame applied in the same cycle overrides below
            case (sweep_q)
                S_DWELL: begin
                    if (dwell_cnt_q >= dwell_q) begin
                        dwell_cnt_q <= '0;
                        sweep_q     <= S_STEP;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
                    end
                end
                S_STEP: begin
                    sweep_q <= S_DWELL;
`ifdef DDS_SWEEP_PINGPONG_EN
                    if (dir_up_q) begin
                        if (up_fits_c) begin
                            KW_Out <= nxt_up_c[KW_W-1:0];
                        end else begin
                            dir_up_q <= 1'b0;
                            KW_Out   <= dn_clamp_c;
                        end
                    end else if (KW_Out > start_q) begin
                        KW_Out <= dn_clamp_c;
                    end else begin
                        dir_up_q <= 1'b1;
                        if (single_q) begin
                            sweep_q    <= S_IDLE;
                            Sweep_Busy <= 1'b0;
                            KW_Out     <= start_q;
                        end else if (up_fits_c) begin
                            KW_Out <= nxt_up_c[KW_W-1:0];
                        end
                    end
`else
                    KW_Out <= up_fits_c ? nxt_up_c[KW_W-1:0] : start_q;
`endif
                end
                default: ;
            endcase

            // Frame parser with inter-byte timeout
            if (parse_q == P_HUNT) begin
                if (Rx_Done && (Rx_Data == 8'hAA)) begin
                    parse_q   <= P_GOT_HDR;
                    tmo_cnt_q <= '0;
                end
            end else if (Rx_Done) begin
                tmo_cnt_q <= '0;
                case (parse_q)
                    P_GOT_HDR: begin
                        if ((Rx_Data >= 8'h01) && (Rx_Data <= 8'h06)) begin
                            cmd_q   <= Rx_Data[2:0];
                            parse_q <= P_GOT_CMD;
                        end else begin
                            Cmd_Err <= 1'b1;
                            parse_q <= P_HUNT;
                        end
                    end
                    P_GOT_CMD: begin
                        d_hi_q  <= Rx_Data;
                        parse_q <= P_GOT_HI;
                    end
                    default: begin
                        parse_q <= P_HUNT;
                        Cmd_Ack <= 1'b1;
                        case (cmd_q)
                            3'd1: begin
                                SW_Sin_Out      <= (data_c[1:0] == 2'd1);
                                SW_Square_Out   <= (data_c[1:0] == 2'd2);
                                SW_Sawtooth_Out <= (data_c[1:0] == 2'd3);
                            end
                            3'd2: begin
                                start_q <= KW_W'(data_c);
                                if (sweep_q == S_IDLE) KW_Out <= KW_W'(data_c);
                            end
                            3'd3: stop_q  <= KW_W'(data_c);
                            3'd4: step_q  <= KW_W'(data_c);
                            3'd5: dwell_q <= DWELL_W'(data_c);
                            3'd6: begin
                                if (!data_c[0]) begin
                                    sweep_q    <= S_IDLE;
                                    Sweep_Busy <= 1'b0;
                                    KW_Out     <= start_q;
                                end else if (run_ok_c) begin
                                    sweep_q     <= S_DWELL;
                                    dwell_cnt_q <= '0;
                                    Sweep_Busy  <= 1'b1;
                                    KW_Out      <= start_q;
`ifdef DDS_SWEEP_PINGPONG_EN
                                    dir_up_q    <= 1'b1;
                                    single_q    <= data_c[1];
`endif
                                end else begin
                                    Cmd_Ack <= 1'b0;
                                    Cmd_Err <= 1'b1;
                                end
                            end
                            default: begin
                                Cmd_Ack <= 1'b0;
                                Cmd_Err <= 1'b1;
                            end
                        endcase
                    end
                endcase
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                Cmd_Err <= 1'b1;
                parse_q <= P_HUNT;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed scenarios plus random frames, checked every cycle
// against a byte-queue / hold-time reference model of the controller.
module tb_dds_sweep_ctrl;

    localparam int unsigned KW_W   = 12;
    localparam int unsigned TMO    = 200;
    localparam int unsigned KW_RST = 1;

    logic            CLK = 1'b0;
    logic            RST;
    logic [7:0]      Rx_Data;
    logic            Rx_Done;
    logic            SW_Sin_Out, SW_Square_Out, SW_Sawtooth_Out;
    logic [KW_W-1:0] KW_Out;
    logic            Sweep_Busy, Cmd_Ack, Cmd_Err;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int         m_start, m_stop, m_step, m_dwell, m_kw, m_wave, m_hold, m_sil;
    bit         m_busy, m_ack, m_err;
    logic [7:0] m_q[$];

    dds_sweep_ctrl #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .Rx_Data(Rx_Data), .Rx_Done(Rx_Done),
        .SW_Sin_Out(SW_Sin_Out), .SW_Square_Out(SW_Square_Out),
        .SW_Sawtooth_Out(SW_Sawtooth_Out), .KW_Out(KW_Out), .Sweep_Busy(Sweep_Busy),
        .Cmd_Ack(Cmd_Ack), .Cmd_Err(Cmd_Err)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_start = KW_RST; m_stop = 4095; m_step = 1; m_dwell = 0; m_kw = KW_RST;
        m_wave = 0; m_hold = 0; m_sil = 0; m_busy = 0; m_ack = 0; m_err = 0;
        m_q.delete();
    endtask

    task automatic model_apply(input int cmd, input int data);
        m_ack = 1;
        case (cmd)
            1: m_wave = data % 4;
            2: begin m_start = data % 4096; if (!m_busy) m_kw = m_start; end
            3: m_stop  = data % 4096;
            4: m_step  = data % 4096;
            5: m_dwell = data;
            default: begin
                if (data % 2 == 0) begin
                    m_busy = 0; m_kw = m_start;
                end else if (m_start > m_stop || m_step == 0) begin
                    m_ack = 0; m_err = 1;
                end else begin
                    m_busy = 1; m_kw = m_start; m_hold = 0;
                end
            end
        endcase
    endtask

    // One clock edge of the reference: sweep timing first, then the byte stream
    task automatic model_step(input logic rst, input logic done, input logic [7:0] data);
        int nxt;
        if (rst) begin model_reset(); return; end
        m_ack = 0; m_err = 0;
        if (m_busy) begin
            if (m_hold >= m_dwell + 1) begin
                nxt    = m_kw + m_step;
                m_kw   = (nxt <= m_stop) ? nxt : m_start;
                m_hold = 0;
            end else begin
                m_hold++;
            end
        end
        if (!done) begin
            if (m_q.size() > 0) begin
                m_sil++;
                if (m_sil >= TMO) begin m_err = 1; m_q.delete(); end
            end
        end else begin
            m_sil = 0;
            if (m_q.size() == 0) begin
                if (data == 8'hAA) m_q.push_back(data);
            end else begin
                m_q.push_back(data);
                if (m_q.size() == 2 && !(data >= 8'd1 && data <= 8'd6)) begin
                    m_err = 1; m_q.delete();
                end else if (m_q.size() == 4) begin
                    model_apply(int'(m_q[1]), int'({m_q[2], m_q[3]}));
                    m_q.delete();
                end
            end
        end
    endtask

    function automatic logic [2:0] exp_sw();
        case (m_wave)
            1: return 3'b100;
            2: return 3'b010;
            3: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check("kw_out", 32'(KW_Out), 32'(m_kw));
        check("sweep_busy", 32'(Sweep_Busy), 32'(m_busy));
        check("sw_sel", 32'({SW_Sin_Out, SW_Square_Out, SW_Sawtooth_Out}), 32'(exp_sw()));
        check("cmd_ack", 32'(Cmd_Ack), 32'(m_ack));
        check("cmd_err", 32'(Cmd_Err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step(RST, Rx_Done, Rx_Data);
        #1;
        Rx_Done = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        Rx_Data = b;
        Rx_Done = 1'b1;
        tick();
        idle(gap);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] data);
        send_byte(8'hAA, 1);
        send_byte(cmd, 1);
        send_byte(data[15:8], 1);
        send_byte(data[7:0], 1);
    endtask

    task automatic wait_kw(input int kw);
        int n = 0;
        while (m_kw != kw && n < 300) begin tick(); n++; end
        tests++;
        assert (n < 300) else begin
            fails++;
            $error("FAIL wait_kw: got %0d cycles, expected under 300", n);
        end
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [15:0] data;
        RST = 1'b1; Rx_Done = 1'b0; Rx_Data = 8'h00;
        model_reset();
        #1;
        check_all();
        idle(2);
        RST = 1'b0;
        idle(2);

        // Waveform select
        send_frame(8'h01, 16'h0002);
        send_frame(8'h01, 16'h0001);
        send_frame(8'h01, 16'h0003);

        // Sawtooth sweep 10..40 step 10, each value held 5 cycles
        send_frame(8'h02, 16'd10);
        send_frame(8'h03, 16'd40);
        send_frame(8'h04, 16'd10);
        send_frame(8'h05, 16'd3);
        send_frame(8'h06, 16'd1);
        idle(30);

        // Lower STOP mid-sweep, then stop
        send_frame(8'h06, 16'd0);
        send_frame(8'h05, 16'd20);
        send_frame(8'h06, 16'd1);
        wait_kw(30);
        send_frame(8'h03, 16'd25);
        idle(30);
        send_frame(8'h06, 16'd0);
        idle(3);

        // Rejected RUN: START>STOP, then STEP==0
        send_frame(8'h05, 16'd3);
        send_frame(8'h02, 16'd50);
        send_frame(8'h03, 16'd40);
        send_frame(8'h06, 16'd1);
        send_frame(8'h02, 16'd10);
        send_frame(8'h04, 16'd0);
        send_frame(8'h06, 16'd1);
        send_frame(8'h04, 16'd10);

        // Inter-byte timeout, then a clean frame
        send_byte(8'hAA, 1);
        send_byte(8'h01, 0);
        idle(TMO + 3);
        send_frame(8'h01, 16'h0002);
        // Byte arriving in the expiry cycle is accepted
        send_byte(8'hAA, 1);
        send_byte(8'h01, TMO - 1);
        send_byte(8'h00, TMO - 1);
        send_byte(8'h03, 2);

        // Garbage before header and an unknown command
        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h07, 1);
        send_byte(8'h00, 1);
        send_byte(8'h00, 2);

        // Reset mid-frame while sweeping
        send_frame(8'h06, 16'd1);
        idle(7);
        send_byte(8'hAA, 1);
        send_byte(8'h02, 1);
        RST = 1'b1;
        model_reset();
        #1;
        check_all();
        idle(2);
        RST = 1'b0;
        idle(1);
        send_frame(8'h01, 16'h0001);

        // Random frames, garbage and partial frames
        for (int it = 0; it < 160; it++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)), $urandom_range(1, 2));
            if ($urandom_range(0, 19) == 0) begin
                send_byte(8'hAA, 1);
                send_byte(8'($urandom_range(1, 6)), 0);
                idle(TMO + 1);
            end
            cmd = 8'($urandom_range(0, 7));
            if (cmd == 8'd5 && m_busy) cmd = 8'd1;
            case (cmd)
                8'd2:    data = 16'($urandom_range(0, 200));
                8'd3:    data = 16'($urandom_range(50, 400));
                8'd4:    data = 16'($urandom_range(0, 40));
                8'd5:    data = 16'($urandom_range(0, 4));
                8'd6:    data = 16'($urandom_range(0, 3));
                default: data = 16'($urandom_range(0, 65535));
            endcase
            send_byte(8'hAA, $urandom_range(1, 3));
            send_byte(cmd, $urandom_range(1, 3));
            send_byte(data[15:8], $urandom_range(1, 3));
            send_byte(data[7:0], $urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
